vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Raster timing constants and helpers shared by the VGA timing
//               generator and its per-axis counter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned c_CNT_W   = 10;
    localparam int unsigned c_CNT_MAX = 1023;

    // 640x480@60 (lowRes)
    localparam int unsigned c_LR_H_ACTIVE = 640;
    localparam int unsigned c_LR_H_FP     = 16;
    localparam int unsigned c_LR_H_SYNC   = 96;
    localparam int unsigned c_LR_H_BP     = 48;
    localparam int unsigned c_LR_V_ACTIVE = 480;
    localparam int unsigned c_LR_V_FP     = 10;
    localparam int unsigned c_LR_V_SYNC   = 2;
    localparam int unsigned c_LR_V_BP     = 33;

    // 1024x768@60; its 1344-pixel line needs a wider count than c_CNT_W
    localparam int unsigned c_HR_H_ACTIVE = 1024;
    localparam int unsigned c_HR_H_FP     = 24;
    localparam int unsigned c_HR_H_SYNC   = 136;
    localparam int unsigned c_HR_H_BP     = 160;
    localparam int unsigned c_HR_V_ACTIVE = 768;
    localparam int unsigned c_HR_V_FP     = 3;
    localparam int unsigned c_HR_V_SYNC   = 6;
    localparam int unsigned c_HR_V_BP     = 29;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned ha, input int unsigned hf,
                                            input int unsigned hs, input int unsigned hb);
        return axis_total(ha, hf, hs, hb);
    endfunction

    function automatic int unsigned v_total(input int unsigned va, input int unsigned vf,
                                            input int unsigned vs, input int unsigned vb);
        return axis_total(va, vf, vs, vb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter with registered
//               active-region and sync flags derived from the next count.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE      = 640,
    parameter int unsigned FP          = 16,
    parameter int unsigned SYNC        = 96,
    parameter int unsigned BP          = 48,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               advance,
    output logic [c_CNT_W-1:0] count,
    output logic               wrap,
    output logic               active,
    output logic               sync
);

    localparam int unsigned        c_TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [c_CNT_W-1:0] c_LAST       = c_CNT_W'(c_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] c_ACTIVE     = c_CNT_W'(ACTIVE);
    localparam logic [c_CNT_W-1:0] c_SYNC_START = c_CNT_W'(ACTIVE + FP);
    localparam logic [c_CNT_W-1:0] c_SYNC_END   = c_CNT_W'(ACTIVE + FP + SYNC);

    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_active_nxt;
    logic               w_sync_nxt;

    // wrap is combinational so the next axis can advance on the same edge
    always_comb begin
        wrap        = (count == c_LAST);
        w_count_nxt = count;
        if (advance) begin
            w_count_nxt = wrap ? '0 : count + 1'b1;
        end
        w_active_nxt = (w_count_nxt < c_ACTIVE);
        w_sync_nxt   = (w_count_nxt >= c_SYNC_START) && (w_count_nxt < c_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= c_LAST;
            active <= 1'b0;
            sync   <= ~SYNC_ACTIVE;
        end else begin
            count  <= w_count_nxt;
            active <= w_active_nxt;
            sync   <= w_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing source: pixel/line position, video-active,
//               sync levels and line/frame start pulses, all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = c_LR_H_ACTIVE,
    parameter int unsigned H_FP        = c_LR_H_FP,
    parameter int unsigned H_SYNC      = c_LR_H_SYNC,
    parameter int unsigned H_BP        = c_LR_H_BP,
    parameter int unsigned V_ACTIVE    = c_LR_V_ACTIVE,
    parameter int unsigned V_FP        = c_LR_V_FP,
    parameter int unsigned V_SYNC      = c_LR_V_SYNC,
    parameter int unsigned V_BP        = c_LR_V_BP,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [31:0] hPixel,
    output logic [31:0] line,
    output logic        video_active,
    output logic        hSync,
    output logic        vSync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned c_H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 || c_H_TOTAL > c_CNT_MAX)
    begin : g_bad_h_params
        $error("vga_timing_gen: horizontal timing parameters out of range");
    end

    if (V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || c_V_TOTAL > c_CNT_MAX)
    begin : g_bad_v_params
        $error("vga_timing_gen: vertical timing parameters out of range");
    end

    logic [c_CNT_W-1:0] w_h_count;
    logic [c_CNT_W-1:0] w_v_count;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_active;
    logic               w_v_active;
    logic               w_v_advance;
    logic               r_line_start;
    logic               r_frame_start;

    assign w_v_advance = pix_en & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE      (H_ACTIVE),
        .FP          (H_FP),
        .SYNC        (H_SYNC),
        .BP          (H_BP),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (pix_en),
        .count   (w_h_count),
        .wrap    (w_h_wrap),
        .active  (w_h_active),
        .sync    (hSync)
    );

    vga_axis_counter #(
        .ACTIVE      (V_ACTIVE),
        .FP          (V_FP),
        .SYNC        (V_SYNC),
        .BP          (V_BP),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (w_v_advance),
        .count   (w_v_count),
        .wrap    (w_v_wrap),
        .active  (w_v_active),
        .sync    (vSync)
    );

    // Pulses fire on the edge the counters wrap, so they align with (0,x)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_v_advance;
            r_frame_start <= w_v_advance & w_v_wrap;
        end
    end

    assign hPixel       = {{(32 - c_CNT_W){1'b0}}, w_h_count};
    assign line         = {{(32 - c_CNT_W){1'b0}}, w_v_count};
    assign video_active = w_h_active & w_v_active;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;

endmodule
`default_nettype wire
